// File: rtl/factor_cycler_if.sv
// Switch-side inputs and display-side outputs of the factor sequencer.
// The master modport drives the number and freeze inputs; the slave modport is the sequencer itself.
interface factor_cycler_if #(
  parameter int WIDTH   = 8,
  parameter int MAX_DIV = 15
);
  localparam int DW = $clog2(MAX_DIV + 1);

  logic [WIDTH-1:0] number;
  logic             freeze;
  logic [DW-1:0]    digit;
  logic             new_factor;
  logic             is_prime;
  logic             prime_valid;
  logic             pass_done;

  modport master (
    output number, freeze,
    input  digit, new_factor, is_prime, prime_valid, pass_done
  );

  modport slave (
    input  number, freeze,
    output digit, new_factor, is_prime, prime_valid, pass_done
  );
endinterface

// File: rtl/factor_cycler.sv
// Factor-display sequencer: walks divisors 1..MAX_DIV of the input number using a
// bit-serial remainder engine, holds each divisor DWELL cycles and flags primality per pass.
module factor_cycler #(
  parameter int WIDTH   = 8,
  parameter int MAX_DIV = 15,
  parameter int DWELL   = 10_000_000
) (
  input  logic            clk,
  input  logic            reset,
  factor_cycler_if.slave  bus
);
  localparam int DW    = $clog2(MAX_DIV + 1);
  localparam int CW    = DW + 1;
  localparam int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DCW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int CMP_W = (WIDTH > CW) ? WIDTH : CW;

  typedef enum logic [1:0] {LOAD, ZERO, SHOW, TEST} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [DW-1:0]    digit_q, digit_d;
  logic             nf_q, nf_d, pd_q, pd_d;
  logic             ip_q, ip_d, pv_q, pv_d;
  logic             found_q, found_d;
  logic [DCW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]    cand_q, cand_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [BW-1:0]    bit_q, bit_d;

  logic             do_exit;
  logic [CW-1:0]    next_c;
  logic [CW-1:0]    step;

  // One restoring-division step; remainder always stays below the candidate.
  function automatic logic [CW-1:0] rem_step(input logic [CW-1:0] rem,
                                             input logic b,
                                             input logic [CW-1:0] c);
    logic [CW-1:0] r;
    r = {rem[CW-2:0], b};
    return (r >= c) ? (r - c) : r;
  endfunction

  function automatic logic can_test(input logic [CW-1:0] c, input logic [WIDTH-1:0] n);
    return (c <= CW'(MAX_DIV)) && (CMP_W'(c) <= CMP_W'(n));
  endfunction

  assign step = rem_step(rem_q, num_q[bit_q], cand_q);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    digit_d = digit_q;
    nf_d    = 1'b0;
    pd_d    = 1'b0;
    ip_d    = ip_q;
    pv_d    = pv_q;
    found_d = found_q;
    dwell_d = dwell_q;
    cand_d  = cand_q;
    rem_d   = rem_q;
    bit_d   = bit_q;
    do_exit = 1'b0;
    next_c  = cand_q;

    case (state_q)
      LOAD: begin
        num_d   = bus.number;
        found_d = 1'b0;
        nf_d    = 1'b1;
        if (bus.number == '0) begin
          digit_d = '0;
          pv_d    = 1'b1;
          ip_d    = 1'b0;
          state_d = ZERO;
        end else begin
          digit_d = DW'(1);
          dwell_d = '0;
          cand_d  = CW'(2);
          state_d = SHOW;
        end
      end
      ZERO: ;
      SHOW: begin
        if (!bus.freeze) begin
          if (dwell_q == DCW'(DWELL - 1)) begin
            do_exit = 1'b1;
            next_c  = cand_q;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      TEST: begin
        if (!bus.freeze) begin
          rem_d = step;
          if (bit_q == '0) begin
            if (step == '0) begin
              digit_d = cand_q[DW-1:0];
              nf_d    = 1'b1;
              dwell_d = '0;
              if (CMP_W'(cand_q) < CMP_W'(num_q)) found_d = 1'b1;
              cand_d  = cand_q + 1'b1;
              state_d = SHOW;
            end else begin
              do_exit = 1'b1;
              next_c  = cand_q + 1'b1;
            end
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Either start testing the next candidate or wrap the pass back to divisor 1.
    if (do_exit) begin
      if (can_test(next_c, num_q)) begin
        cand_d  = next_c;
        rem_d   = '0;
        bit_d   = BW'(WIDTH - 1);
        state_d = TEST;
      end else begin
        pd_d    = 1'b1;
        pv_d    = 1'b1;
        ip_d    = (num_q >= WIDTH'(2)) && !found_q;
        found_d = 1'b0;
        digit_d = DW'(1);
        nf_d    = 1'b1;
        dwell_d = '0;
        cand_d  = CW'(2);
        state_d = SHOW;
      end
    end

    // A new number overrides freeze and every other transition.
    if (state_q != LOAD && bus.number != num_q) begin
      state_d = LOAD;
      digit_d = digit_q;
      pv_d    = 1'b0;
      ip_d    = 1'b0;
      nf_d    = 1'b0;
      pd_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      num_q   <= '0;
      digit_q <= '0;
      nf_q    <= 1'b0;
      pd_q    <= 1'b0;
      ip_q    <= 1'b0;
      pv_q    <= 1'b0;
      found_q <= 1'b0;
      dwell_q <= '0;
      cand_q  <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      digit_q <= digit_d;
      nf_q    <= nf_d;
      pd_q    <= pd_d;
      ip_q    <= ip_d;
      pv_q    <= pv_d;
      found_q <= found_d;
      dwell_q <= dwell_d;
      cand_q  <= cand_d;
      rem_q   <= rem_d;
      bit_q   <= bit_d;
    end
  end

  assign bus.digit       = digit_q;
  assign bus.new_factor  = nf_q;
  assign bus.pass_done   = pd_q;
  assign bus.is_prime    = ip_q;
  assign bus.prime_valid = pv_q;
endmodule
